// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of one selected
// channel over a programmable gate window. Optional alarm via RO_FREQ_METER_ALARM_EN.
module ro_freq_meter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned GATE_W = 16,
    localparam int unsigned CH_W  = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ro_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start,
    input  logic              cont,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_data,
    output logic [CH_W-1:0]   res_ch,
    output logic              res_valid,
    output logic              ovf,
    output logic              busy
`ifdef RO_FREQ_METER_ALARM_EN
    ,
    input  logic [CNT_W-1:0]  thresh,
    output logic              alarm
`endif
);

    localparam int unsigned CH_N = 1 << CH_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_CH-1:0]  sync1;
    logic [NUM_CH-1:0]  sync2;
    logic [NUM_CH-1:0]  hist;
    logic [CH_N-1:0]    sync_pad;
    logic [CH_N-1:0]    hist_pad;
    logic [CH_W-1:0]    ch_lat;
    logic [GATE_W-1:0]  gate_cnt;
    logic               gate_last;
    logic               settle_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ovf_acc;
    logic               ovf_nxt;
    logic               rise;
    logic               latch;
    logic               count_en;
    logic               capture;
    logic               release_res;

    // Unused select codes (ch_sel >= NUM_CH) read as a static-low channel.
    assign sync_pad  = CH_N'(sync2);
    assign hist_pad  = CH_N'(hist);
    assign rise      = sync_pad[ch_lat] & ~hist_pad[ch_lat];
    assign gate_last = (gate_cnt == GATE_W'(1));

    // Saturating edge counter; an edge at full scale flags overflow instead.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf_acc;
        if (rise) begin
            if (cnt == {CNT_W{1'b1}}) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt) state_nxt = GATE;
            GATE:    if (gate_last) state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = cont ? SETTLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        latch       = 1'b0;
        count_en    = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: latch = start;
            GATE: begin
                count_en = 1'b1;
                capture  = gate_last;
            end
            HOLD: begin
                release_res = res_ready;
                latch       = res_ready & cont;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            hist       <= '0;
            ch_lat     <= '0;
            gate_cnt   <= '0;
            settle_cnt <= 1'b0;
            cnt        <= '0;
            ovf_acc    <= 1'b0;
            res_data   <= '0;
            res_ch     <= '0;
            res_valid  <= 1'b0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            hist  <= sync2;
            busy  <= (state_nxt != IDLE);

            if (latch) begin
                ch_lat     <= ch_sel;
                gate_cnt   <= (gate_len == '0) ? GATE_W'(1) : gate_len;
                settle_cnt <= 1'b0;
                cnt        <= '0;
                ovf_acc    <= 1'b0;
                ovf        <= 1'b0;
            end else if (state == SETTLE) begin
                settle_cnt <= ~settle_cnt;
            end

            if (count_en) begin
                cnt      <= cnt_nxt;
                ovf_acc  <= ovf_nxt;
                gate_cnt <= gate_cnt - GATE_W'(1);
            end

            // Result includes any edge seen in the final gate cycle.
            if (capture) begin
                res_data  <= cnt_nxt;
                res_ch    <= ch_lat;
                ovf       <= ovf_nxt;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef RO_FREQ_METER_ALARM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (capture) begin
            alarm <= (cnt_nxt >= thresh) | ovf_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: logs every driven ro_in value per cycle and predicts each
// result by counting rising edges of that log inside the gate window.
module tb_ro_freq_meter;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned GATE_W = 16;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned SAT_W  = 4;
    localparam int          MAXC   = 20000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ro_in;
    logic [CH_W-1:0]   ch_sel;
    logic [GATE_W-1:0] gate_len;
    logic              start;
    logic              cont;
    logic              res_ready;
    logic [CNT_W-1:0]  res_data;
    logic [CH_W-1:0]   res_ch;
    logic              res_valid;
    logic              ovf;
    logic              busy;
    logic [SAT_W-1:0]  s_res_data;
    logic [CH_W-1:0]   s_res_ch;
    logic              s_res_valid;
    logic              s_ovf;
    logic              s_busy;
`ifdef RO_FREQ_METER_ALARM_EN
    logic [CNT_W-1:0]  thresh;
    logic              alarm;
    logic              s_alarm;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [NUM_CH-1:0] ro_log [MAXC];
    int   per [NUM_CH];
    int   ph  [NUM_CH];
    logic lvl [NUM_CH];

    ro_freq_meter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
        .clk(clk), .rst(rst), .ro_in(ro_in), .ch_sel(ch_sel), .gate_len(gate_len),
        .start(start), .cont(cont), .res_ready(res_ready), .res_data(res_data),
        .res_ch(res_ch), .res_valid(res_valid), .ovf(ovf), .busy(busy)
`ifdef RO_FREQ_METER_ALARM_EN
        , .thresh(thresh), .alarm(alarm)
`endif
    );

    ro_freq_meter #(.NUM_CH(NUM_CH), .CNT_W(SAT_W), .GATE_W(GATE_W)) dut_sat (
        .clk(clk), .rst(rst), .ro_in(ro_in), .ch_sel(ch_sel), .gate_len(gate_len),
        .start(start), .cont(cont), .res_ready(res_ready), .res_data(s_res_data),
        .res_ch(s_res_ch), .res_valid(s_res_valid), .ovf(s_ovf), .busy(s_busy)
`ifdef RO_FREQ_METER_ALARM_EN
        , .thresh(thresh[SAT_W-1:0]), .alarm(s_alarm)
`endif
    );

    always #5 clk = ~clk;

    // Oscillator driver: square waves (or static levels), changed 1 after each rising clk.
    initial begin
        logic [NUM_CH-1:0] v;
        ro_in     = '0;
        ro_log[0] = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (per[c] < 2) v[c] = lvl[c];
                else            v[c] = (((cyc + ph[c]) % per[c]) < (per[c] / 2));
            end
            ro_in = v;
            if (cyc < MAXC) ro_log[cyc] = v;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Edge in input cycle c is seen by the counter two cycles later, so a window
    // of gate cycles T+3..T+2+N covers input rises in cycles T+1..T+N.
    function automatic int exp_raw(input int ch, input int t, input int n);
        int neff = (n == 0) ? 1 : n;
        int r = 0;
        for (int c = t + 1; c <= t + neff; c++) begin
            if (ro_log[c][ch] && !ro_log[c-1][ch]) r++;
        end
        return r;
    endfunction

    task automatic set_wave(input int ch, input int p, input int phase, input logic level);
        per[ch] = p;
        ph[ch]  = phase;
        lvl[ch] = level;
    endtask

    task automatic do_start(input int ch, input int n, output int t);
        ch_sel   = CH_W'(ch);
        gate_len = GATE_W'(n);
        start    = 1'b1;
        t        = cyc;
        tick();
        start    = 1'b0;
        ch_sel   = CH_W'($urandom);
        gate_len = GATE_W'($urandom_range(0, 300));
    endtask

    // Waits for res_valid while throwing ignored start/ready/config noise at the DUT.
    task automatic wait_valid(input int deadline, output int arr);
        while (!res_valid && cyc < deadline + 8) begin
            start     = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            ch_sel    = CH_W'($urandom);
            gate_len  = GATE_W'($urandom_range(0, 300));
            tick();
        end
        start     = 1'b0;
        res_ready = 1'b0;
        arr       = res_valid ? cyc : -1;
    endtask

    task automatic check_result(input string tag, input int ch, input int t, input int n,
                                output int sat16);
        int raw, sat4;
        raw   = exp_raw(ch, t, n);
        sat16 = (raw > 65535) ? 65535 : raw;
        sat4  = (raw > 15) ? 15 : raw;
        check({tag, "_data"},     64'(res_data),   64'(sat16));
        check({tag, "_ch"},       64'(res_ch),     64'(ch));
        check({tag, "_ovf"},      64'(ovf),        64'(raw > 65535));
        check({tag, "_sat_data"}, 64'(s_res_data), 64'(sat4));
        check({tag, "_sat_ovf"},  64'(s_ovf),      64'(raw > 15));
        check({tag, "_sat_ch"},   64'(s_res_ch),   64'(ch));
`ifdef RO_FREQ_METER_ALARM_EN
        check({tag, "_alarm"},     64'(alarm),   64'((sat16 >= int'(thresh)) || (raw > 65535)));
        check({tag, "_sat_alarm"}, 64'(s_alarm),
              64'((sat4 >= int'(thresh[SAT_W-1:0])) || (raw > 15)));
`endif
    endtask

    task automatic measure(input string tag, input int ch, input int n, input int dly);
        int t, arr, sat16;
        int neff = (n == 0) ? 1 : n;
        cont = 1'b0;
        do_start(ch, n, t);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        wait_valid(t + 3 + neff, arr);
        check({tag, "_lat"}, 64'(arr), 64'(t + 3 + neff));
        check_result(tag, ch, t, n, sat16);
        repeat (dly) begin
            ch_sel   = CH_W'($urandom);
            gate_len = GATE_W'($urandom);
            start    = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        check({tag, "_hold"}, 64'({res_valid, res_data}), 64'({1'b1, CNT_W'(sat16)}));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_drop"}, 64'({res_valid, busy, s_res_valid, s_busy}), 64'(0));
    endtask

    initial begin
        int t, h, arr, sat16, neff, bad;
        rst       = 1'b1;
        start     = 1'b0;
        cont      = 1'b0;
        res_ready = 1'b0;
        ch_sel    = '0;
        gate_len  = '0;
`ifdef RO_FREQ_METER_ALARM_EN
        thresh    = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) set_wave(c, 0, 0, 1'b0);

        // Reset state.
        repeat (3) tick();
        check("rst_valid", 64'(res_valid), 64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_data",  64'(res_data),  64'(0));
        check("rst_ch",    64'(res_ch),    64'(0));
        check("rst_ovf",   64'(ovf),       64'(0));
`ifdef RO_FREQ_METER_ALARM_EN
        check("rst_alarm", 64'(alarm),     64'(0));
`endif
        rst = 1'b0;
        repeat (3) tick();

        // Nominal: channel 1 rising every 10 clk, 99-cycle gate.
        set_wave(1, 10, 3, 1'b0);
        set_wave(0, 3, 0, 1'b0);
        repeat (12) tick();
`ifdef RO_FREQ_METER_ALARM_EN
        thresh = CNT_W'(8);
`endif
        measure("nom_t8", 1, 99, 3);
        check("nom_range", 64'((res_data >= 9) && (res_data <= 11)), 64'(1));
`ifdef RO_FREQ_METER_ALARM_EN
        thresh = CNT_W'(11);
`endif
        measure("nom_t11", 1, 99, 0);
`ifdef RO_FREQ_METER_ALARM_EN
        check("nom_t11_alarm_held", 64'(alarm), 64'(0));
`endif

        // Saturation on the narrow-counter instance.
        set_wave(0, 4, 1, 1'b0);
        measure("sat", 0, 200, 2);
        check("sat_full", 64'({s_res_data, s_ovf}), 64'({4'd15, 1'b1}));

        // Zero gate length with static inputs.
        for (int c = 0; c < NUM_CH; c++) set_wave(c, 0, 0, 1'b1);
        repeat (4) tick();
        measure("gate0", 3, 0, 1);

        // Continuous mode: result held against back-pressure, then auto re-arm.
        set_wave(1, 6, 0, 1'b0);
        set_wave(2, 8, 2, 1'b0);
        cont = 1'b1;
        do_start(1, 30, t);
        wait_valid(t + 33, arr);
        check("cont1_lat", 64'(arr), 64'(t + 33));
        check_result("cont1", 1, t, 30, sat16);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            ch_sel = CH_W'($urandom);
            start  = 1'($urandom_range(0, 1));
            tick();
            if ({res_valid, busy, res_data} !== {1'b1, 1'b1, CNT_W'(sat16)}) bad++;
        end
        start = 1'b0;
        check("cont1_stall_held", 64'(bad), 64'(0));
        ch_sel    = CH_W'(2);
        gate_len  = GATE_W'(20);
        res_ready = 1'b1;
        h         = cyc;
        tick();
        res_ready = 1'b0;
        check("cont_rearm", 64'({res_valid, busy}), 64'({1'b0, 1'b1}));
        wait_valid(h + 23, arr);
        check("cont2_lat", 64'(arr), 64'(h + 23));
        check_result("cont2", 2, h, 20, sat16);
        cont      = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("cont2_end", 64'({res_valid, busy}), 64'(0));
        repeat (6) tick();
        check("cont2_idle", 64'({res_valid, busy}), 64'(0));

        // Reset in the middle of a gate window discards that window.
        do_start(2, 50, t);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_clear", 64'({res_valid, busy, s_res_valid, s_busy}), 64'(0));
        bad = 0;
        repeat (70) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("abort_no_result", 64'(bad), 64'(0));
        measure("after_abort", 2, 40, 2);

        // Randomized windows, channels, waveforms and back-pressure.
        for (int it = 0; it < 10; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                set_wave(c, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 16)),
                         int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
`ifdef RO_FREQ_METER_ALARM_EN
            thresh = CNT_W'($urandom_range(0, 14));
`endif
            repeat (3) tick();
            neff = int'($urandom_range(0, 80));
            measure("rnd", int'($urandom_range(0, NUM_CH - 1)), neff,
                    int'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
